divisao_num_matriz: RTL and testbench

DIVISAO_NUM_MATRIZ -- requirements
Module: divisao_num_matriz

---
 rtl/divisao_num_matriz.sv | 147 ++++++++++++++
 tb/tb_divisao_num_matriz.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/divisao_num_matriz.sv
// divisao_num_matriz: divides up to 25 signed 8-bit matrix elements by a signed 8-bit divisor (sequential restoring divider); ports clk, rst (async high), start, matriz_A/num_inteiro/matrix_size in; nova_matriz_A, busy, done, overflow_flag, div_zero_flag out; optional DIV_REMAINDER_EN adds resto_matriz
module divisao_num_matriz (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [199:0] matriz_A,
  input  logic [7:0]   num_inteiro,
  input  logic [1:0]   matrix_size,
  output logic [199:0] nova_matriz_A,
  output logic         busy,
  output logic         done,
  output logic         overflow_flag,
`ifdef DIV_REMAINDER_EN
  output logic [199:0] resto_matriz,
`endif
  output logic         div_zero_flag
);
  typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, FINISH} state_t;
  state_t state_q, state_d;
  logic [199:0] a_q, a_d, res_q, res_d;
  logic [7:0] d_q, d_d, b_q, b_d, r_q, r_d, q_q, q_d, cur;
  logic [1:0] size_q, size_d;
  logic [4:0] idx_q, idx_d, n;
  logic [2:0] cnt_q, cnt_d;
  logic sq_q, sq_d, ovf_q, ovf_d, dz_q, dz_d, done_q, done_d;
  logic [8:0] sh, diff;
`ifdef DIV_REMAINDER_EN
  logic [199:0] rem_q, rem_d;
  logic sa_q, sa_d;
`endif
  assign cur  = a_q[idx_q*8 +: 8];
  assign n    = size_q == 2'd0 ? 5'd4 : size_q == 2'd1 ? 5'd9 : size_q == 2'd2 ? 5'd16 : 5'd25;
  // restoring step: partial remainder shifted left with the next dividend bit, which leaves q_q MSB first
  assign sh   = {r_q, q_q[7]};
  assign diff = sh - {1'b0, b_q};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    d_d = d_q;
    size_d = size_q;
    res_d = res_q;
    b_d = b_q;
    r_d = r_q;
    q_d = q_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    sq_d = sq_q;
    ovf_d = ovf_q;
    dz_d = dz_q;
`ifdef DIV_REMAINDER_EN
    rem_d = rem_q;
    sa_d = sa_q;
`endif
    done_d = state_q == FINISH;
    case (state_q)
      IDLE: if (start) begin
        a_d = matriz_A;
        d_d = num_inteiro;
        size_d = matrix_size;
        res_d = '0;
        ovf_d = 1'b0;
        dz_d = num_inteiro == 8'd0;
        idx_d = '0;
`ifdef DIV_REMAINDER_EN
        rem_d = '0;
`endif
        state_d = num_inteiro == 8'd0 ? FINISH : LOAD;
      end
      LOAD: begin
        q_d = cur[7] ? -cur : cur;
        b_d = d_q[7] ? -d_q : d_q;
        sq_d = cur[7] ^ d_q[7];
`ifdef DIV_REMAINDER_EN
        sa_d = cur[7];
`endif
        r_d = '0;
        cnt_d = '0;
        state_d = DIV;
      end
      DIV: begin
        r_d = diff[8] ? sh[7:0] : diff[7:0];
        q_d = {q_q[6:0], ~diff[8]};
        cnt_d = cnt_q + 3'd1;
        state_d = cnt_q == 3'd7 ? STORE : DIV;
      end
      STORE: begin
        // magnitude 128 with positive sign is only reachable as -128/-1; its bit pattern is already 8'h80
        res_d[idx_q*8 +: 8] = sq_q ? -q_q : q_q;
        ovf_d = ovf_q | (~sq_q & q_q[7]);
`ifdef DIV_REMAINDER_EN
        rem_d[idx_q*8 +: 8] = sa_q ? -r_q : r_q;
`endif
        idx_d = idx_q + 5'd1;
        state_d = idx_q + 5'd1 < n ? LOAD : FINISH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      d_q <= '0;
      size_q <= '0;
      res_q <= '0;
      b_q <= '0;
      r_q <= '0;
      q_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      sq_q <= 1'b0;
      ovf_q <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rem_q <= '0;
      sa_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      d_q <= d_d;
      size_q <= size_d;
      res_q <= res_d;
      b_q <= b_d;
      r_q <= r_d;
      q_q <= q_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      sq_q <= sq_d;
      ovf_q <= ovf_d;
      dz_q <= dz_d;
      done_q <= done_d;
`ifdef DIV_REMAINDER_EN
      rem_q <= rem_d;
      sa_q <= sa_d;
`endif
    end
  assign nova_matriz_A = res_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign overflow_flag = ovf_q;
  assign div_zero_flag = dz_q;
`ifdef DIV_REMAINDER_EN
  assign resto_matriz = rem_q;
`endif
endmodule

// File: tb/tb_divisao_num_matriz.sv
// tb_divisao_num_matriz: directed self-checking bench for divisao_num_matriz
module tb_divisao_num_matriz;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [199:0] matriz_A = '0, nova_matriz_A, exp_m, m;
  logic [7:0] num_inteiro = '0;
  logic [1:0] matrix_size = '0;
  logic busy, done, overflow_flag, div_zero_flag;
`ifdef DIV_REMAINDER_EN
  logic [199:0] resto_matriz, exp_r;
`endif
  int checks = 0, failures = 0, lat;
  always #5 clk = ~clk;
  divisao_num_matriz dut (
    .clk(clk), .rst(rst), .start(start), .matriz_A(matriz_A), .num_inteiro(num_inteiro),
    .matrix_size(matrix_size), .nova_matriz_A(nova_matriz_A), .busy(busy), .done(done),
    .overflow_flag(overflow_flag),
`ifdef DIV_REMAINDER_EN
    .resto_matriz(resto_matriz),
`endif
    .div_zero_flag(div_zero_flag)
  );
  function automatic logic [7:0] model_q(input logic [7:0] a, input logic [7:0] d);
    int x;
    x = int'($signed(a)) / int'($signed(d));
    return x[7:0];
  endfunction
  task automatic go(input logic [1:0] sz, input logic [199:0] mm, input logic [7:0] d, output int l);
    @(negedge clk);
    matrix_size = sz;
    matriz_A = mm;
    num_inteiro = d;
    start = 1'b1;
    l = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (!done && l < 400) begin
      @(negedge clk);
      l++;
    end
  endtask
  task automatic cmp_matrix(input string nm);
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (nova_matriz_A[i*8 +: 8] !== exp_m[i*8 +: 8]) begin
        failures++;
        $display("FAIL %s elem%0d got=%h exp=%h", nm, i, nova_matriz_A[i*8 +: 8], exp_m[i*8 +: 8]);
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, overflow_flag, div_zero_flag} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, overflow_flag, div_zero_flag}); end
    checks++; if (nova_matriz_A !== 200'd0) begin failures++; $display("FAIL reset_matrix got=%h exp=0", nova_matriz_A); end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored got=%b exp=0", busy); end
    start = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_2x2;
    m = '0;
    m[7:0] = 8'd10; m[15:8] = 8'hF9; m[23:16] = 8'd127; m[31:24] = 8'h80;
    m[39:32] = 8'h55;
    go(2'b00, m, 8'd3, lat);
    exp_m = '0;
    exp_m[7:0] = 8'd3; exp_m[15:8] = 8'hFE; exp_m[23:16] = 8'd42; exp_m[31:24] = 8'hD6;
    checks++; if (lat !== 41) begin failures++; $display("FAIL 2x2_latency got=%0d exp=41", lat); end
    checks++; if (overflow_flag !== 1'b0) begin failures++; $display("FAIL 2x2_overflow got=%b exp=0", overflow_flag); end
    checks++; if (div_zero_flag !== 1'b0) begin failures++; $display("FAIL 2x2_divzero got=%b exp=0", div_zero_flag); end
    cmp_matrix("2x2");
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL 2x2_done_pulse got=%b exp=0", done); end
  endtask
  task automatic test_truncation;
    m = '0;
    m[7:0] = 8'hF9; m[15:8] = 8'd7; m[23:16] = 8'h80; m[31:24] = 8'd100;
    go(2'b00, m, 8'hFE, lat);
    exp_m = '0;
    exp_m[7:0] = 8'd3; exp_m[15:8] = 8'hFD; exp_m[23:16] = 8'd64; exp_m[31:24] = 8'hCE;
    cmp_matrix("trunc");
    checks++; if (overflow_flag !== 1'b0) begin failures++; $display("FAIL trunc_overflow got=%b exp=0", overflow_flag); end
  endtask
  task automatic test_overflow;
    m = '0;
    m[7:0] = 8'h80;
    for (int i = 1; i < 25; i++) m[i*8 +: 8] = 8'(i * 5 - 60);
    go(2'b01, m, 8'hFF, lat);
    exp_m = '0;
    exp_m[7:0] = 8'h80;
    for (int i = 1; i < 9; i++) exp_m[i*8 +: 8] = 8'(60 - i * 5);
    checks++; if (lat !== 91) begin failures++; $display("FAIL ovf_latency got=%0d exp=91", lat); end
    checks++; if (overflow_flag !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow_flag); end
    cmp_matrix("ovf");
    matriz_A = '1;
    num_inteiro = 8'd1;
    repeat (10) @(negedge clk);
    checks++; if (overflow_flag !== 1'b1) begin failures++; $display("FAIL ovf_hold got=%b exp=1", overflow_flag); end
    cmp_matrix("ovf_hold");
  endtask
  task automatic test_div_zero;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(i + 1);
    go(2'b11, m, 8'd0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    checks++; if (div_zero_flag !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_zero_flag); end
    checks++; if (overflow_flag !== 1'b0) begin failures++; $display("FAIL dz_ovf_cleared got=%b exp=0", overflow_flag); end
    checks++; if (nova_matriz_A !== 200'd0) begin failures++; $display("FAIL dz_matrix got=%h exp=0", nova_matriz_A); end
  endtask
  task automatic test_busy_ignore;
    m = '0;
    m[7:0] = 8'd20; m[15:8] = 8'd21; m[23:16] = 8'd22; m[31:24] = 8'd23;
    @(negedge clk);
    matrix_size = 2'b00; matriz_A = m; num_inteiro = 8'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 15) begin matriz_A = '1; num_inteiro = 8'd1; matrix_size = 2'b11; start = 1'b1; end
      if (lat == 16) start = 1'b0;
    end
    exp_m = '0;
    for (int i = 0; i < 4; i++) exp_m[i*8 +: 8] = 8'd4;
    checks++; if (lat !== 41) begin failures++; $display("FAIL busy_latency got=%0d exp=41", lat); end
    cmp_matrix("busy");
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_second_start got=%b exp=0", busy); end
  endtask
  task automatic test_back_to_back;
    m = '0;
    m[7:0] = 8'd50; m[15:8] = 8'hCE;
    go(2'b00, m, 8'd7, lat);
    m = '0;
    m[7:0] = 8'd99; m[15:8] = 8'h9D; m[23:16] = 8'd1; m[31:24] = 8'hFF;
    go(2'b00, m, 8'hF6, lat);
    exp_m = '0;
    exp_m[7:0] = 8'hF7; exp_m[15:8] = 8'd9;
    checks++; if (lat !== 41) begin failures++; $display("FAIL b2b_latency got=%0d exp=41", lat); end
    cmp_matrix("b2b");
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(i * 13 - 90);
    @(negedge clk);
    matrix_size = 2'b10; matriz_A = m; num_inteiro = 8'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (53) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, overflow_flag, div_zero_flag} !== 4'b0) begin failures++; $display("FAIL mid_reset_flags got=%b exp=0000", {busy, done, overflow_flag, div_zero_flag}); end
    checks++; if (nova_matriz_A !== 200'd0) begin failures++; $display("FAIL mid_reset_matrix got=%h exp=0", nova_matriz_A); end
    @(negedge clk);
    rst = 1'b0;
    go(2'b10, m, 8'd6, lat);
    exp_m = '0;
    for (int i = 0; i < 16; i++) exp_m[i*8 +: 8] = model_q(m[i*8 +: 8], 8'd6);
    checks++; if (lat !== 161) begin failures++; $display("FAIL mid_latency got=%0d exp=161", lat); end
    cmp_matrix("mid");
  endtask
  task automatic test_5x5;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(i * 37 + 3);
    go(2'b11, m, 8'hF9, lat);
    for (int i = 0; i < 25; i++) exp_m[i*8 +: 8] = model_q(m[i*8 +: 8], 8'hF9);
    checks++; if (lat !== 251) begin failures++; $display("FAIL 5x5_latency got=%0d exp=251", lat); end
    cmp_matrix("5x5");
  endtask
`ifdef DIV_REMAINDER_EN
  task automatic test_remainder;
    m = '0;
    m[7:0] = 8'hF9; m[15:8] = 8'd7; m[23:16] = 8'd9; m[39:32] = 8'd77;
    go(2'b00, m, 8'd2, lat);
    exp_m = '0;
    exp_m[7:0] = 8'hFD; exp_m[15:8] = 8'd3; exp_m[23:16] = 8'd4;
    exp_r = '0;
    exp_r[7:0] = 8'hFF; exp_r[15:8] = 8'd1; exp_r[23:16] = 8'd1;
    cmp_matrix("rem_q");
    checks++; if (resto_matriz !== exp_r) begin failures++; $display("FAIL rem_values got=%h exp=%h", resto_matriz, exp_r); end
  endtask
`endif
  initial begin
    test_reset;
    test_2x2;
    test_truncation;
    test_overflow;
    test_div_zero;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    test_5x5;
`ifdef DIV_REMAINDER_EN
    test_remainder;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
